// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers a four-digit BCD frame from a scanned 7-segment display bus
module seg_scan_decoder #(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] bcd,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  err_mask
);

    localparam logic [0:0] TRACK = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [7:0] STABLE_C = 8'(STABLE);

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [10:0] last_pat;
    logic [10:0] cur_pat;
    logic [7:0]  run_cnt;
    logic [7:0]  run_next;
    logic [15:0] pend_val;
    logic [3:0]  pend_err;
    logic [3:0]  cap_mask;
    logic [3:0]  mask_after;
    logic        publish;
    logic        publish_next;
    logic        eligible;
    logic        changed;
    logic        capture;
    logic [3:0]  dig;
    logic        dig_err;

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Returns {invalid, digit}; unknown patterns (blank included) map to F.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   return 5'h00;
            7'h30:   return 5'h01;
            7'h6D:   return 5'h02;
            7'h79:   return 5'h03;
            7'h33:   return 5'h04;
            7'h5B:   return 5'h05;
            7'h5F:   return 5'h06;
            7'h70:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h7B:   return 5'h09;
            default: return 5'h1F;
        endcase
    endfunction

    assign cur_pat = {an, seg};
    assign eligible = onehot4(an);
    assign changed = (cur_pat != last_pat);
    assign {dig_err, dig} = decode(seg);

    always_comb begin
        run_next = 8'd0;
        if (changed) begin
            run_next = eligible ? 8'd1 : 8'd0;
        end else if (!eligible) begin
            run_next = 8'd0;
        end else if (run_cnt >= STABLE_C) begin
            run_next = STABLE_C;
        end else begin
            run_next = run_cnt + 8'd1;
        end
    end

    // HOLD blocks a second capture until the bus shows something different.
    always_comb begin
        capture    = (state == TRACK) && (run_next == STABLE_C);
        state_next = state;
        case (state)
            TRACK:   if (capture) state_next = HOLD;
            HOLD:    if (changed) state_next = TRACK;
            default: state_next = TRACK;
        endcase
    end

    // A capture landing on the publish edge starts the next frame's mask.
    always_comb begin
        mask_after   = (publish ? 4'd0 : cap_mask) | (capture ? an : 4'd0);
        publish_next = capture && (mask_after == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TRACK;
            last_pat    <= 11'd0;
            run_cnt     <= 8'd0;
            pend_val    <= 16'h0000;
            pend_err    <= 4'h0;
            cap_mask    <= 4'h0;
            publish     <= 1'b0;
            bcd         <= 16'h0000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_mask    <= 4'h0;
        end else begin
            state       <= state_next;
            last_pat    <= cur_pat;
            run_cnt     <= run_next;
            cap_mask    <= mask_after;
            publish     <= publish_next;
            frame_valid <= publish;
            if (publish) begin
                bcd       <= pend_val;
                err_mask  <= pend_err;
                frame_err <= |pend_err;
            end
            for (int n = 0; n < 4; n++) begin
                if (capture && an[n]) begin
                    pend_val[4*n +: 4] <= dig;
                    pend_err[n]        <= dig_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'h0;
    logic [6:0]  seg = 7'h00;
    logic [15:0] bcd;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  err_mask;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulse_iter = -1;
    int viol = 0;
    logic [15:0] last_bcd = 16'h0;
    logic [15:0] first_bcd = 16'h0;
    logic [15:0] bcd_prev = 16'h0;
    logic        last_fe = 1'b0;
    logic [3:0]  last_em = 4'h0;

    seg_scan_decoder #(.STABLE(4)) dut (
        .clk(clk),
        .rst(rst),
        .an(an),
        .seg(seg),
        .bcd(bcd),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic sample(input int i);
        if (frame_valid === 1'b1) begin
            pulses++;
            if (pulses == 1) first_bcd = bcd;
            last_bcd   = bcd;
            last_fe    = frame_err;
            last_em    = err_mask;
            pulse_iter = i;
        end else if (bcd !== bcd_prev) begin
            viol++;
        end
        bcd_prev = bcd;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample(i);
            an  = a;
            seg = s;
        end
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        hold(4'b0001, s0, 6);
        hold(4'b0010, s1, 6);
        hold(4'b0100, s2, 6);
        hold(4'b1000, s3, 6);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        an  = 4'h0;
        seg = 7'h00;
        repeat (n) @(negedge clk);
        rst      = 1'b0;
        bcd_prev = bcd;
        pulses   = 0;
    endtask

    initial begin
        // Reset values
        do_reset(2);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        chk("reset_fe", 32'(frame_err), 32'h0);
        chk("reset_em", 32'(err_mask), 32'h0);
        chk("reset_mask", 32'(dut.cap_mask), 32'h0);

        // In-order scan 0..3
        pulse_iter = -1;
        scan(7'h7E, 7'h30, 7'h6D, 7'h79);
        chk("scan_latency_iter", 32'(pulse_iter), 32'd5);
        hold(4'b0000, 7'h00, 3);
        chk("scan_pulses", 32'(pulses), 32'd1);
        chk("scan_bcd", 32'(last_bcd), 32'h3210);
        chk("scan_fe", 32'(last_fe), 32'h0);
        chk("scan_em", 32'(last_em), 32'h0);
        chk("scan_bcd_held", 32'(bcd), 32'h3210);

        // Stability: 3 cycles of "4" never captured, "5" captured once
        pulses = 0;
        hold(4'b0001, 7'h33, 3);
        hold(4'b0001, 7'h5B, 4);
        hold(4'b0000, 7'h00, 2);
        chk("stable_mask", 32'(dut.cap_mask), 32'h1);
        chk("stable_no_pulse", 32'(pulses), 32'd0);
        hold(4'b0010, 7'h30, 6);
        hold(4'b0100, 7'h6D, 6);
        hold(4'b1000, 7'h79, 6);
        hold(4'b0000, 7'h00, 3);
        chk("stable_pulses", 32'(pulses), 32'd1);
        chk("stable_bcd", 32'(last_bcd), 32'h3215);

        // Invalid (blank) digit 2
        pulses = 0;
        scan(7'h7F, 7'h7B, 7'h00, 7'h70);
        hold(4'b0000, 7'h00, 3);
        chk("inv_pulses", 32'(pulses), 32'd1);
        chk("inv_bcd", 32'(last_bcd), 32'h7F98);
        chk("inv_em", 32'(last_em), 32'h4);
        chk("inv_fe", 32'(last_fe), 32'h1);
        chk("inv_fe_held", 32'(frame_err), 32'h1);

        // Illegal strobes leave the captured mask alone
        do_reset(1);
        hold(4'b0001, 7'h7E, 6);
        hold(4'b0000, 7'h00, 1);
        hold(4'b0011, 7'h30, 10);
        hold(4'b0000, 7'h30, 10);
        chk("illegal_pulses", 32'(pulses), 32'd0);
        chk("illegal_mask", 32'(dut.cap_mask), 32'h1);
        hold(4'b0010, 7'h30, 6);
        hold(4'b0100, 7'h6D, 6);
        hold(4'b1000, 7'h79, 6);
        hold(4'b0000, 7'h00, 3);
        chk("illegal_after_pulses", 32'(pulses), 32'd1);
        chk("illegal_after_bcd", 32'(last_bcd), 32'h3210);

        // Reset mid-frame discards digits 0..2
        do_reset(1);
        hold(4'b0001, 7'h5B, 6);
        hold(4'b0010, 7'h5F, 6);
        hold(4'b0100, 7'h70, 6);
        do_reset(1);
        hold(4'b1000, 7'h7F, 6);
        hold(4'b0000, 7'h00, 3);
        chk("midrst_pulses", 32'(pulses), 32'd0);
        chk("midrst_bcd", 32'(bcd), 32'h0);
        scan(7'h30, 7'h6D, 7'h79, 7'h7E);
        hold(4'b0000, 7'h00, 3);
        chk("midrst_full_pulses", 32'(pulses), 32'd1);
        chk("midrst_full_bcd", 32'(last_bcd), 32'h8321);

        // Back-to-back rotations 9,8,7,6
        do_reset(1);
        scan(7'h7B, 7'h7F, 7'h70, 7'h5F);
        scan(7'h7B, 7'h7F, 7'h70, 7'h5F);
        hold(4'b0000, 7'h00, 3);
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first_bcd", 32'(first_bcd), 32'h6789);
        chk("b2b_last_bcd", 32'(last_bcd), 32'h6789);
        hold(4'b0001, 7'h7B, 20);
        hold(4'b0000, 7'h00, 3);
        chk("b2b_held_pulses", 32'(pulses), 32'd2);
        chk("b2b_held_mask", 32'(dut.cap_mask), 32'h1);

        chk("bcd_changes_only_on_publish", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
